uart_program_loader: RTL and testbench
======================================

Name: uart_program_loader

Overview:
- Writer side of the K2 program memory: receives a program over UART and stores it in a 16x10 instruction RAM.
- The processor reads that RAM through the same `ProgramAddress` → `instruction_data` combinational port it uses with the fixed program ROMs.
- Holds the processor in reset (`cpu_rst_n`) from reset/sync until a complete, error-free program has been written.
- Sits beside `K2_processor_withMem` in place of a hard-coded program ROM.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per UART bit (50 MHz / 9600 baud); must be ≥ 4.
- DEPTH, 16, instruction words; address width is clog2(DEPTH) = 4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- Rx  in  1  UART serial input, idle high, asynchronous to clk
- include_parity  in  1  1 = frame carries a parity bit after the data
- parity_type  in  1  0 = even, 1 = odd
- ProgramAddress  in  4  processor read address
- instruction_data  out  10  mem[ProgramAddress], combinational
- cpu_rst_n  out  1  active-low reset to the processor
- load_done  out  1  high while a complete program is resident
- load_error  out  1  sticky error flag
- loaded_count  out  5  number of words written by the last successful load (0..16)

Behaviour:
- Reset values:
  - mem all 0; `instruction_data` = 0.
  - `cpu_rst_n` = 0, `load_done` = 0, `load_error` = 0, `loaded_count` = 0.
  - Loader FSM in WAIT_SYNC, receiver in IDLE.
- Reset mid-operation aborts everything immediately; it does not resume.
- Rx path: 2-flop synchronizer; internal rx_s is reset to 1.
- UART receiver frame: start(0), 8 data bits LSB first, optional parity, stop(1).
  - Start detection: falling edge of rx_s.
  - Start bit re-checked at CLKS_PER_BIT/2 cycles; if rx_s is high there, it is a false start → IDLE, no byte.
  - Each later bit is sampled at CLKS_PER_BIT intervals from that mid-start point.
  - `include_parity` and `parity_type` are latched at start confirmation; mid-frame changes are ignored.
  - Parity error: XOR(data, parity bit) ≠ parity_type.
  - Framing error: stop sample = 0.
  - At the stop-bit sample, exactly one single-cycle pulse is issued: byte_valid (no error) or byte_err.
  - After a framing error, the receiver waits for rx_s = 1 before arming again.
- Loader FSM (acts only on byte_valid / byte_err pulses):
  - WAIT_SYNC: byte 0xA5 → WAIT_COUNT, clear `load_error`, `cpu_rst_n` = 0, `load_done` = 0. Other bytes and errors are ignored.
  - WAIT_COUNT: byte N, 1 ≤ N ≤ 16 → latch N, wptr = 0, WAIT_HI. N = 0 or N > 16 → `load_error` = 1, WAIT_SYNC.
  - WAIT_HI: byte b → hold b[1:0] as inst[9:8] (b[7:2] ignored) → WAIT_LO.
  - WAIT_LO: byte b → write mem[wptr] = {hi, b} on that clock, wptr++.
    - If wptr was N−1 → DONE, `loaded_count` = N, `load_done` = 1, `cpu_rst_n` = 1 on the next clk edge.
    - Otherwise → WAIT_HI.
  - DONE: byte 0xA5 → same action as in WAIT_SYNC (restart load, processor back in reset). Other bytes ignored.
  - byte_err in WAIT_COUNT, WAIT_HI or WAIT_LO → `load_error` = 1, WAIT_SYNC, `cpu_rst_n` stays 0, `loaded_count` unchanged. Words already written remain.
- Memory:
  - Addresses ≥ N keep their prior contents.
  - Writes occur only while `cpu_rst_n` = 0, so there is no read/write hazard.
  - The read port is purely combinational; the new value is visible the cycle after the write edge.
- `cpu_rst_n` is a registered output, glitch-free.
- `load_done` and `cpu_rst_n` are high together only in DONE.

Test Plan (CLKS_PER_BIT = 8, include_parity = 0 unless stated):
- Reset, idle Rx=1 for 500 cycles → `cpu_rst_n` = 0, `load_done` = 0, `instruction_data` = 0 for all addresses.
- Send A5, 03, 01 2C, 00 FF, 03 00 → mem[0..2] = 0x12C, 0x0FF, 0x300, mem[3] = 0.
  - `loaded_count` = 3, `load_done` = 1, `cpu_rst_n` rises within 1 cycle of the last stop-bit sample.
- After a complete load, send A5 then 10, then 16 word pairs → `cpu_rst_n` = 0 from the A5 until the 16th write, then `loaded_count` = 16.
  - Every `ProgramAddress` 0..15 reads back its word.
- include_parity = 1, parity_type = 0: send A5, 02, then 0x01 with the wrong parity bit → `load_error` = 1, FSM in WAIT_SYNC, `cpu_rst_n` = 0.
  - A following valid A5 clears `load_error`.
- Send A5, 00 → `load_error` = 1. Send A5, 11 → `load_error` = 1. In both cases mem is unchanged.
- Rx low pulse of 3 cycles (false start) → no byte. A stop bit forced to 0 during WAIT_HI → `load_error` = 1.
- `rst_n` asserted during WAIT_LO → all outputs return to reset values asynchronously, mem = 0.

Source files
------------

// File: rtl/uart_program_loader_if.sv
// Bundle between the UART program loader and whoever drives it: serial input
// and frame options in, processor-facing instruction read port and load status
// out, plus the two FSM states for observation.
interface uart_program_loader_if #(
    parameter int AW = 4,   // instruction address width
    parameter int CW = 5    // loaded word count width (0..DEPTH)
);
    logic          Rx;
    logic          include_parity;
    logic          parity_type;
    logic [AW-1:0] ProgramAddress;
    logic [9:0]    instruction_data;
    logic          cpu_rst_n;
    logic          load_done;
    logic          load_error;
    logic [CW-1:0] loaded_count;
    logic [2:0]    dbg_loader_state;
    logic [2:0]    dbg_rx_state;

    // Loader side
    modport slave (
        input  Rx, include_parity, parity_type, ProgramAddress,
        output instruction_data, cpu_rst_n, load_done, load_error,
               loaded_count, dbg_loader_state, dbg_rx_state
    );

    // Environment side (serial source and processor)
    modport master (
        output Rx, include_parity, parity_type, ProgramAddress,
        input  instruction_data, cpu_rst_n, load_done, load_error,
               loaded_count, dbg_loader_state, dbg_rx_state
    );
endinterface

// File: rtl/uart_program_loader.sv
// UART program loader: receives a framed program (0xA5, word count N, then N
// hi/lo byte pairs) over a serial line and writes it into a 16x10 instruction
// RAM. The processor is held in reset until a full, error-free load finishes.
//
// Internal byte handshake: the receiver raises exactly one of byte_valid or
// byte_err for a single cycle at the stop-bit sample, with byte_data stable in
// that cycle. There is no backpressure; the loader consumes every pulse in the
// cycle it appears.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DEPTH        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_program_loader_if.slave  bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;
    localparam logic [7:0]       MAX_WORDS = 8'(DEPTH);

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_t;

    typedef enum logic [2:0] {
        LD_WAIT_SYNC  = 3'd0,
        LD_WAIT_COUNT = 3'd1,
        LD_WAIT_HI    = 3'd2,
        LD_WAIT_LO    = 3'd3,
        LD_DONE       = 3'd4
    } ld_state_t;

    // ---------------------------------------------------------------- Rx sync
    logic rx_meta_q, rx_s_q, rx_prev_q;
    logic rx_fall;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.Rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_s_q;

    // ---------------------------------------------------------------- receiver
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_en_q, par_en_d;
    logic             par_type_q, par_type_d;
    logic             par_bit_q, par_bit_d;
    logic             byte_valid, byte_err;
    logic [7:0]       byte_data;

    // Receiver state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            par_bit_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            par_bit_q  <= par_bit_d;
        end
    end

    // Receiver next state: mid-start recheck, then one sample per bit period
    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        par_bit_d  = par_bit_q;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        byte_data  = shreg_q;

        case (rx_state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_fall) rx_state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        // Frame options are frozen here for the whole frame
                        rx_state_d = RX_DATA;
                        bit_idx_d  = '0;
                        par_en_d   = bus.include_parity;
                        par_type_d = bus.parity_type;
                    end else begin
                        rx_state_d = RX_IDLE;  // glitch, not a start bit
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s_q, shreg_q[7:1]};  // LSB arrives first
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = par_en_q ? RX_PARITY : RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d      = '0;
                    par_bit_d  = rx_s_q;
                    rx_state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        byte_err   = 1'b1;          // framing error
                        rx_state_d = RX_WAIT_HIGH;
                    end else if (par_en_q && ((^shreg_q ^ par_bit_q) != par_type_q)) begin
                        byte_err   = 1'b1;          // parity error
                        rx_state_d = RX_IDLE;
                    end else begin
                        byte_valid = 1'b1;
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                // Line may still be low (break); do not arm until it idles
                if (rx_s_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- loader
    ld_state_t     ld_state_q, ld_state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [1:0]    hi_q, hi_d;
    logic          load_error_q, load_error_d;
    logic          cpu_rst_n_q, cpu_rst_n_d;
    logic          load_done_q, load_done_d;
    logic [CW-1:0] loaded_count_q, loaded_count_d;
    logic          mem_we;
    logic [9:0]    mem_q [DEPTH];

    // Loader state and status registers (all outputs come straight from flops)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_state_q     <= LD_WAIT_SYNC;
            count_q        <= '0;
            wptr_q         <= '0;
            hi_q           <= '0;
            load_error_q   <= 1'b0;
            cpu_rst_n_q    <= 1'b0;
            load_done_q    <= 1'b0;
            loaded_count_q <= '0;
        end else begin
            ld_state_q     <= ld_state_d;
            count_q        <= count_d;
            wptr_q         <= wptr_d;
            hi_q           <= hi_d;
            load_error_q   <= load_error_d;
            cpu_rst_n_q    <= cpu_rst_n_d;
            load_done_q    <= load_done_d;
            loaded_count_q <= loaded_count_d;
        end
    end

    // Loader next state: sync, count, then hi/lo pairs until N words written
    always_comb begin
        ld_state_d     = ld_state_q;
        count_d        = count_q;
        wptr_d         = wptr_q;
        hi_d           = hi_q;
        load_error_d   = load_error_q;
        cpu_rst_n_d    = cpu_rst_n_q;
        load_done_d    = load_done_q;
        loaded_count_d = loaded_count_q;
        mem_we         = 1'b0;

        case (ld_state_q)
            LD_WAIT_SYNC, LD_DONE: begin
                // A sync byte always restarts a load, even over a resident one
                if (byte_valid && byte_data == SYNC_BYTE) begin
                    ld_state_d   = LD_WAIT_COUNT;
                    load_error_d = 1'b0;
                    cpu_rst_n_d  = 1'b0;
                    load_done_d  = 1'b0;
                end
            end
            LD_WAIT_COUNT: begin
                if (byte_err) begin
                    load_error_d = 1'b1;
                    ld_state_d   = LD_WAIT_SYNC;
                end else if (byte_valid) begin
                    if (byte_data != 8'd0 && byte_data <= MAX_WORDS) begin
                        count_d    = CW'(byte_data);
                        wptr_d     = '0;
                        ld_state_d = LD_WAIT_HI;
                    end else begin
                        load_error_d = 1'b1;
                        ld_state_d   = LD_WAIT_SYNC;
                    end
                end
            end
            LD_WAIT_HI: begin
                if (byte_err) begin
                    load_error_d = 1'b1;
                    ld_state_d   = LD_WAIT_SYNC;
                end else if (byte_valid) begin
                    hi_d       = byte_data[1:0];
                    ld_state_d = LD_WAIT_LO;
                end
            end
            LD_WAIT_LO: begin
                if (byte_err) begin
                    load_error_d = 1'b1;
                    ld_state_d   = LD_WAIT_SYNC;
                end else if (byte_valid) begin
                    mem_we = 1'b1;
                    wptr_d = wptr_q + 1'b1;
                    if (CW'(wptr_q) == CW'(count_q - 1'b1)) begin
                        ld_state_d     = LD_DONE;
                        loaded_count_d = count_q;
                        load_done_d    = 1'b1;
                        cpu_rst_n_d    = 1'b1;
                    end else begin
                        ld_state_d = LD_WAIT_HI;
                    end
                end
            end
            default: ld_state_d = LD_WAIT_SYNC;
        endcase
    end

    // Instruction RAM write port; only written while the processor is in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[wptr_q] <= {hi_q, byte_data};
        end
    end

    assign bus.instruction_data = mem_q[bus.ProgramAddress];
    assign bus.cpu_rst_n        = cpu_rst_n_q;
    assign bus.load_done        = load_done_q;
    assign bus.load_error       = load_error_q;
    assign bus.loaded_count     = loaded_count_q;
    assign bus.dbg_loader_state = ld_state_q;
    assign bus.dbg_rx_state     = rx_state_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: directed UART frames, a status-event
// scoreboard, and direct readback of the instruction RAM.
module tb_uart_program_loader;
    localparam int CPB = 8;

    localparam logic [2:0] LD_WAIT_SYNC  = 3'd0;
    localparam logic [2:0] LD_WAIT_COUNT = 3'd1;
    localparam logic [2:0] LD_WAIT_HI    = 3'd2;
    localparam logic [2:0] LD_WAIT_LO    = 3'd3;
    localparam logic [2:0] LD_DONE       = 3'd4;
    localparam logic [2:0] RX_IDLE       = 3'd0;

    // ---------------------------------------------------------- clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_program_loader_if bus ();

    uart_program_loader #(.CLKS_PER_BIT(CPB), .DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] last_status = 8'h00;
    logic [9:0] exp_mem [16];

    // ---------------------------------------------------------- helpers
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < 16; a++) begin
            bus.ProgramAddress = 4'(a);
            #1;
            check($sformatf("%s_mem%0d", tag, a), 32'(bus.instruction_data), 32'(exp_mem[a]));
        end
    endtask

    task automatic idle_bits(input int n);
        bus.Rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    // Drives one frame and returns at the end of the stop bit
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        @(negedge clk);
        bus.Rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.Rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (bus.include_parity) begin
            bus.Rx = (^b) ^ bus.parity_type ^ bad_par;
            repeat (CPB) @(negedge clk);
        end
        bus.Rx = ~bad_stop;
        repeat (CPB) @(negedge clk);
        bus.Rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
        idle_bits(2);
    endtask

    function automatic logic [7:0] st(input bit rst_o, input bit done, input bit err, input logic [4:0] cnt);
        return {rst_o, done, err, cnt};
    endfunction

    // ---------------------------------------------------------- monitor
    // Every change of {cpu_rst_n, load_done, load_error, loaded_count} must
    // match the next expected status word in order.
    always @(negedge clk) begin
        logic [7:0] s;
        logic [7:0] e;
        s = {bus.cpu_rst_n, bus.load_done, bus.load_error, bus.loaded_count};
        if (s !== last_status) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL status_event: got %h expected no change from %h", s, last_status);
            end else begin
                e = exp_q.pop_front();
                if (s !== e) begin
                    bad++;
                    $display("FAIL status_event: got %h expected %h", s, e);
                end
            end
            last_status = s;
        end
    end

    // ---------------------------------------------------------- stimulus
    initial begin
        logic [9:0] w;
        bus.Rx             = 1'b1;
        bus.include_parity = 1'b0;
        bus.parity_type    = 1'b0;
        bus.ProgramAddress = '0;
        for (int i = 0; i < 16; i++) exp_mem[i] = '0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (500) @(negedge clk);

        // Reset/idle state
        check("rst_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
        check("rst_load_done", 32'(bus.load_done), 32'd0);
        check("rst_load_error", 32'(bus.load_error), 32'd0);
        check("rst_loaded_count", 32'(bus.loaded_count), 32'd0);
        check("rst_loader_state", 32'(bus.dbg_loader_state), 32'(LD_WAIT_SYNC));
        check("rst_rx_state", 32'(bus.dbg_rx_state), 32'(RX_IDLE));
        check_mem("rst");

        // Three-word load
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h01); send_byte(8'h2C);
        send_byte(8'h00); send_byte(8'hFF);
        send_byte(8'h03);
        check("load3_held_before_last", 32'(bus.cpu_rst_n), 32'd0);
        exp_q.push_back(st(1'b1, 1'b1, 1'b0, 5'd3));
        send_frame(8'h00, 1'b0, 1'b0);
        check("load3_rst_release_at_stop", 32'(bus.cpu_rst_n), 32'd1);
        idle_bits(2);
        exp_mem[0] = 10'h12C; exp_mem[1] = 10'h0FF; exp_mem[2] = 10'h300;
        check("load3_done", 32'(bus.load_done), 32'd1);
        check("load3_count", 32'(bus.loaded_count), 32'd3);
        check("load3_state", 32'(bus.dbg_loader_state), 32'(LD_DONE));
        check_mem("load3");

        // Full sixteen-word reload over a resident program; hi bytes carry junk in [7:2]
        exp_q.push_back(st(1'b0, 1'b0, 1'b0, 5'd3));
        send_byte(8'hA5);
        send_byte(8'h10);
        for (int i = 0; i < 16; i++) begin
            w = 10'((i * 97 + 13) % 1024);
            if (i == 15) begin
                check("load16_held_before_last", 32'(bus.cpu_rst_n), 32'd0);
                exp_q.push_back(st(1'b1, 1'b1, 1'b0, 5'd16));
            end
            send_byte({6'h2B, w[9:8]});
            send_byte(w[7:0]);
            exp_mem[i] = w;
        end
        check("load16_count", 32'(bus.loaded_count), 32'd16);
        check_mem("load16");

        // Parity error on the first hi byte
        bus.include_parity = 1'b1;
        bus.parity_type    = 1'b0;
        exp_q.push_back(st(1'b0, 1'b0, 1'b0, 5'd16));
        send_byte(8'hA5);
        send_byte(8'h02);
        exp_q.push_back(st(1'b0, 1'b0, 1'b1, 5'd16));
        send_frame(8'h01, 1'b1, 1'b0);
        idle_bits(2);
        check("par_err_flag", 32'(bus.load_error), 32'd1);
        check("par_err_state", 32'(bus.dbg_loader_state), 32'(LD_WAIT_SYNC));
        check("par_err_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
        exp_q.push_back(st(1'b0, 1'b0, 1'b0, 5'd16));
        send_byte(8'hA5);
        check("par_sync_clears_error", 32'(bus.load_error), 32'd0);
        bus.include_parity = 1'b0;

        // Out-of-range counts
        exp_q.push_back(st(1'b0, 1'b0, 1'b1, 5'd16));
        send_byte(8'h00);
        check("count0_error", 32'(bus.load_error), 32'd1);
        check_mem("count0");
        exp_q.push_back(st(1'b0, 1'b0, 1'b0, 5'd16));
        send_byte(8'hA5);
        exp_q.push_back(st(1'b0, 1'b0, 1'b1, 5'd16));
        send_byte(8'h11);
        check("count17_error", 32'(bus.load_error), 32'd1);
        check_mem("count17");

        // False start, then framing error in WAIT_HI
        exp_q.push_back(st(1'b0, 1'b0, 1'b0, 5'd16));
        send_byte(8'hA5);
        @(negedge clk);
        bus.Rx = 1'b0;
        repeat (3) @(negedge clk);
        bus.Rx = 1'b1;
        repeat (5 * CPB) @(negedge clk);
        check("false_start_loader", 32'(bus.dbg_loader_state), 32'(LD_WAIT_COUNT));
        check("false_start_rx", 32'(bus.dbg_rx_state), 32'(RX_IDLE));
        send_byte(8'h01);
        check("count1_state", 32'(bus.dbg_loader_state), 32'(LD_WAIT_HI));
        exp_q.push_back(st(1'b0, 1'b0, 1'b1, 5'd16));
        send_frame(8'h55, 1'b0, 1'b1);
        idle_bits(2);
        check("frame_err_flag", 32'(bus.load_error), 32'd1);
        check("frame_err_state", 32'(bus.dbg_loader_state), 32'(LD_WAIT_SYNC));
        check("frame_err_rx_rearmed", 32'(bus.dbg_rx_state), 32'(RX_IDLE));
        check_mem("frame_err");

        // Asynchronous reset while waiting for a lo byte
        exp_q.push_back(st(1'b0, 1'b0, 1'b0, 5'd16));
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h03);
        check("pre_reset_state", 32'(bus.dbg_loader_state), 32'(LD_WAIT_LO));
        exp_q.push_back(st(1'b0, 1'b0, 1'b0, 5'd0));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
        check("arst_load_done", 32'(bus.load_done), 32'd0);
        check("arst_load_error", 32'(bus.load_error), 32'd0);
        check("arst_loaded_count", 32'(bus.loaded_count), 32'd0);
        check("arst_loader_state", 32'(bus.dbg_loader_state), 32'(LD_WAIT_SYNC));
        for (int i = 0; i < 16; i++) exp_mem[i] = '0;
        check_mem("arst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #2000000;
        bad++;
        $display("FAIL timeout: simulation limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
